muldiv_sequencer: RTL and testbench

//  Front end of the RV32M execute path, between the control unit and the multiplier/divider.

---
 rtl/muldiv_sequencer_pkg.sv | 48 ++++
 rtl/muldiv_sequencer_if.sv | 41 ++++
 rtl/div_special_case.sv | 25 ++
 rtl/muldiv_sequencer.sv | 167 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared constants for the RV32M execute front end: funct3 M-op encodings,
// multiplier/divider op codes and the funct3-to-op mapping helpers.
package muldiv_sequencer_pkg;

    localparam int MUL_OP_WIDTH = 2;
    localparam int DIV_OP_WIDTH = 2;

    typedef logic [MUL_OP_WIDTH-1:0] mul_op_t;
    typedef logic [DIV_OP_WIDTH-1:0] div_op_t;

    localparam mul_op_t MUL_OP_MUL    = 2'd0;
    localparam mul_op_t MUL_OP_MULH   = 2'd1;
    localparam mul_op_t MUL_OP_MULHSU = 2'd2;
    localparam mul_op_t MUL_OP_MULU   = 2'd3;

    localparam div_op_t DIV_OP_DIV  = 2'd0;
    localparam div_op_t DIV_OP_DIVU = 2'd1;
    localparam div_op_t DIV_OP_REM  = 2'd2;
    localparam div_op_t DIV_OP_REMU = 2'd3;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    function automatic mul_op_t mul_op_of(input logic [2:0] f3);
        case (f3)
            F3_MULH:   return MUL_OP_MULH;
            F3_MULHSU: return MUL_OP_MULHSU;
            F3_MULHU:  return MUL_OP_MULU;
            default:   return MUL_OP_MUL;
        endcase
    endfunction

    function automatic div_op_t div_op_of(input logic [2:0] f3);
        case (f3)
            F3_DIVU: return DIV_OP_DIVU;
            F3_REM:  return DIV_OP_REM;
            F3_REMU: return DIV_OP_REMU;
            default: return DIV_OP_DIV;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Bundle between the control unit, the sequencer and the multiplier/divider.
interface muldiv_sequencer_if;
    import muldiv_sequencer_pkg::*;

    // Core holds valid (with funct3/rs1/rs2) high until the one-cycle ready
    // pulse; x_valid and x_ready are single-cycle pulses, one x_ready per x_valid.
    logic        valid;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic [31:0] result;
    logic        ready;

    logic        mul_valid;
    mul_op_t     mul_op;
    logic [31:0] mul_factor1;
    logic [31:0] mul_factor2;
    logic [31:0] mul_product;
    logic        mul_ready;

    logic        div_valid;
    div_op_t     div_op;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic [31:0] div_result;
    logic        div_ready;

    modport slave (
        input  valid, funct3, rs1, rs2, flush, mul_product, mul_ready, div_result, div_ready,
        output result, ready, mul_valid, mul_op, mul_factor1, mul_factor2,
               div_valid, div_op, div_dividend, div_divisor
    );

    modport master (
        output valid, funct3, rs1, rs2, flush, mul_product, mul_ready, div_result, div_ready,
        input  result, ready, mul_valid, mul_op, mul_factor1, mul_factor2,
               div_valid, div_op, div_dividend, div_divisor
    );

endinterface

// File: rtl/div_special_case.sv
// Resolves RV32M divide-by-zero and signed-overflow results without the divider.
module div_special_case (
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [2:0]  funct3,
    output logic        is_special,
    output logic [31:0] special_result
);

    always_comb begin
        is_special     = 1'b0;
        special_result = '0;
        if (funct3[2]) begin
            if (rs2 == 32'h0) begin
                is_special     = 1'b1;
                special_result = funct3[1] ? rs1 : 32'hFFFF_FFFF;
            end else if (!funct3[0] && rs1 == 32'h8000_0000 && rs2 == 32'hFFFF_FFFF) begin
                // Only the signed forms overflow; funct3[1] selects REM over DIV.
                is_special     = 1'b1;
                special_result = funct3[1] ? 32'h0 : 32'h8000_0000;
            end
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M sequencer: accepts M-ops from the core, dispatches them to the multiplier
// or divider, short-circuits special divides and repeated ops, and returns results.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter bit CACHE_EN = 1'b1
) (
    input  logic              clk,
    input  logic              resetn,
    muldiv_sequencer_if.slave bus,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        IDLE, ISSUE_MUL, WAIT_MUL, ISSUE_DIV, WAIT_DIV, DONE, DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] rs1_q, rs1_d, rs2_q, rs2_d;
    logic [31:0] result_q, result_d;
    logic        cache_vld_q, cache_vld_d;
    logic [2:0]  cache_f3_q, cache_f3_d;
    logic [31:0] cache_rs1_q, cache_rs1_d, cache_rs2_q, cache_rs2_d;
    logic [31:0] cache_res_q, cache_res_d;

    logic        is_special;
    logic [31:0] special_result;
    logic        cache_hit;
    logic        ready_c, mul_valid_c, div_valid_c;

    div_special_case u_special (
        .rs1           (bus.rs1),
        .rs2           (bus.rs2),
        .funct3        (bus.funct3),
        .is_special    (is_special),
        .special_result(special_result)
    );

    assign cache_hit = CACHE_EN && cache_vld_q && (cache_f3_q == bus.funct3)
                       && (cache_rs1_q == bus.rs1) && (cache_rs2_q == bus.rs2);

    always_comb begin
        state_d     = state_q;
        f3_d        = f3_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        result_d    = result_q;
        cache_vld_d = cache_vld_q;
        cache_f3_d  = cache_f3_q;
        cache_rs1_d = cache_rs1_q;
        cache_rs2_d = cache_rs2_q;
        cache_res_d = cache_res_q;
        ready_c     = 1'b0;
        mul_valid_c = 1'b0;
        div_valid_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.valid && !bus.flush) begin
                    f3_d  = bus.funct3;
                    rs1_d = bus.rs1;
                    rs2_d = bus.rs2;
                    if (cache_hit) begin
                        result_d = cache_res_q;
                        state_d  = DONE;
                    end else if (is_special) begin
                        result_d = special_result;
                        state_d  = DONE;
                    end else if (!bus.funct3[2]) begin
                        state_d = ISSUE_MUL;
                    end else begin
                        state_d = ISSUE_DIV;
                    end
                end
            end
            // The start pulse goes out even when flushed, so DRAIN always owes one x_ready.
            ISSUE_MUL: begin
                mul_valid_c = 1'b1;
                state_d     = bus.flush ? DRAIN : WAIT_MUL;
            end
            ISSUE_DIV: begin
                div_valid_c = 1'b1;
                state_d     = bus.flush ? DRAIN : WAIT_DIV;
            end
            WAIT_MUL: begin
                if (bus.flush) begin
                    state_d = bus.mul_ready ? IDLE : DRAIN;
                end else if (bus.mul_ready) begin
                    result_d    = bus.mul_product;
                    cache_vld_d = 1'b1;
                    cache_f3_d  = f3_q;
                    cache_rs1_d = rs1_q;
                    cache_rs2_d = rs2_q;
                    cache_res_d = bus.mul_product;
                    state_d     = DONE;
                end
            end
            WAIT_DIV: begin
                if (bus.flush) begin
                    state_d = bus.div_ready ? IDLE : DRAIN;
                end else if (bus.div_ready) begin
                    result_d    = bus.div_result;
                    cache_vld_d = 1'b1;
                    cache_f3_d  = f3_q;
                    cache_rs1_d = rs1_q;
                    cache_rs2_d = rs2_q;
                    cache_res_d = bus.div_result;
                    state_d     = DONE;
                end
            end
            DONE: begin
                ready_c = !bus.flush;
                state_d = IDLE;
            end
            DRAIN: begin
                if (f3_q[2] ? bus.div_ready : bus.mul_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.flush) begin
            cache_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            f3_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            result_q    <= '0;
            cache_vld_q <= 1'b0;
            cache_f3_q  <= '0;
            cache_rs1_q <= '0;
            cache_rs2_q <= '0;
            cache_res_q <= '0;
        end else begin
            state_q     <= state_d;
            f3_q        <= f3_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            result_q    <= result_d;
            cache_vld_q <= cache_vld_d;
            cache_f3_q  <= cache_f3_d;
            cache_rs1_q <= cache_rs1_d;
            cache_rs2_q <= cache_rs2_d;
            cache_res_q <= cache_res_d;
        end
    end

    assign bus.result       = result_q;
    assign bus.ready        = ready_c;
    assign bus.mul_valid    = mul_valid_c;
    assign bus.mul_op       = mul_op_of(f3_q);
    assign bus.mul_factor1  = rs1_q;
    assign bus.mul_factor2  = rs2_q;
    assign bus.div_valid    = div_valid_c;
    assign bus.div_op       = div_op_of(f3_q);
    assign bus.div_dividend = rs1_q;
    assign bus.div_divisor  = rs2_q;
    assign state_dbg        = state_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: two instances (cache on / cache off) behind a
// shared driver, with the tb acting as core and as the multiplier/divider responder.
module tb_muldiv_sequencer;
    import muldiv_sequencer_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    muldiv_sequencer_if if0 ();
    muldiv_sequencer_if if1 ();
    logic [2:0] st0, st1;

    logic        sel;
    logic        drv_valid, drv_flush, drv_mul_ready, drv_div_ready;
    logic [2:0]  drv_f3;
    logic [31:0] drv_rs1, drv_rs2, drv_mul_product, drv_div_result;

    assign if0.valid       = drv_valid & ~sel;
    assign if0.flush       = drv_flush & ~sel;
    assign if0.mul_ready   = drv_mul_ready & ~sel;
    assign if0.div_ready   = drv_div_ready & ~sel;
    assign if0.funct3      = drv_f3;
    assign if0.rs1         = drv_rs1;
    assign if0.rs2         = drv_rs2;
    assign if0.mul_product = drv_mul_product;
    assign if0.div_result  = drv_div_result;

    assign if1.valid       = drv_valid & sel;
    assign if1.flush       = drv_flush & sel;
    assign if1.mul_ready   = drv_mul_ready & sel;
    assign if1.div_ready   = drv_div_ready & sel;
    assign if1.funct3      = drv_f3;
    assign if1.rs1         = drv_rs1;
    assign if1.rs2         = drv_rs2;
    assign if1.mul_product = drv_mul_product;
    assign if1.div_result  = drv_div_result;

    logic        obs_ready, obs_mul_valid, obs_div_valid;
    logic [31:0] obs_result, obs_f1, obs_f2, obs_dvd, obs_dvs;
    mul_op_t     obs_mul_op;
    div_op_t     obs_div_op;

    assign obs_ready     = sel ? if1.ready        : if0.ready;
    assign obs_mul_valid = sel ? if1.mul_valid    : if0.mul_valid;
    assign obs_div_valid = sel ? if1.div_valid    : if0.div_valid;
    assign obs_result    = sel ? if1.result       : if0.result;
    assign obs_f1        = sel ? if1.mul_factor1  : if0.mul_factor1;
    assign obs_f2        = sel ? if1.mul_factor2  : if0.mul_factor2;
    assign obs_dvd       = sel ? if1.div_dividend : if0.div_dividend;
    assign obs_dvs       = sel ? if1.div_divisor  : if0.div_divisor;
    assign obs_mul_op    = sel ? if1.mul_op       : if0.mul_op;
    assign obs_div_op    = sel ? if1.div_op       : if0.div_op;

    muldiv_sequencer #(.CACHE_EN(1'b1)) u_dut (
        .clk      (clk),
        .resetn   (resetn),
        .bus      (if0),
        .state_dbg(st0)
    );

    muldiv_sequencer #(.CACHE_EN(1'b0)) u_dut_nc (
        .clk      (clk),
        .resetn   (resetn),
        .bus      (if1),
        .state_dbg(st1)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_mul_op(input logic [2:0] f3);
        case (f3)
            F3_MUL:    return 32'(MUL_OP_MUL);
            F3_MULH:   return 32'(MUL_OP_MULH);
            F3_MULHSU: return 32'(MUL_OP_MULHSU);
            default:   return 32'(MUL_OP_MULU);
        endcase
    endfunction

    function automatic logic [31:0] exp_div_op(input logic [2:0] f3);
        case (f3)
            F3_DIV:  return 32'(DIV_OP_DIV);
            F3_DIVU: return 32'(DIV_OP_DIVU);
            F3_REM:  return 32'(DIV_OP_REM);
            default: return 32'(DIV_OP_REMU);
        endcase
    endfunction

    // exp_edges: clock edges from the accepting edge to the ready cycle (0 = no ready).
    task automatic run_op(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] unit_res, input int unit_lat,
                          input int exp_mul, input int exp_div,
                          input int exp_edges, input logic [31:0] exp_res, input int flush_k);
        int n_mul = 0;
        int n_div = 0;
        int n_ready = 0;
        int ready_k = 0;
        int pend_mul = 0;
        int pend_div = 0;
        @(negedge clk);
        drv_valid       = 1'b1;
        drv_f3          = f3;
        drv_rs1         = a;
        drv_rs2         = b;
        drv_mul_product = unit_res;
        drv_div_result  = unit_res;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (obs_ready) begin
                n_ready++;
                if (ready_k == 0) begin
                    ready_k = k;
                    check({tag, "_result"}, obs_result, exp_res);
                end
            end
            if (obs_mul_valid) begin
                n_mul++;
                check({tag, "_mul_op"}, 32'(obs_mul_op), exp_mul_op(f3));
                check({tag, "_factor1"}, obs_f1, a);
                check({tag, "_factor2"}, obs_f2, b);
            end
            if (obs_div_valid) begin
                n_div++;
                check({tag, "_div_op"}, 32'(obs_div_op), exp_div_op(f3));
                check({tag, "_dividend"}, obs_dvd, a);
                check({tag, "_divisor"}, obs_dvs, b);
            end
            drv_mul_ready = 1'b0;
            drv_div_ready = 1'b0;
            drv_flush     = 1'b0;
            if (pend_mul > 0) begin
                pend_mul--;
                if (pend_mul == 0) begin
                    drv_mul_ready = 1'b1;
                    check({tag, "_factor1_final"}, obs_f1, a);
                    check({tag, "_factor2_final"}, obs_f2, b);
                end
            end
            if (pend_div > 0) begin
                pend_div--;
                if (pend_div == 0) drv_div_ready = 1'b1;
            end
            if (obs_mul_valid) pend_mul = unit_lat;
            if (obs_div_valid) pend_div = unit_lat;
            if (k == flush_k) begin
                drv_flush = 1'b1;
                drv_valid = 1'b0;
            end
            if (ready_k != 0 && k == ready_k + 1) drv_valid = 1'b0;
        end
        drv_valid = 1'b0;
        check({tag, "_mul_pulses"}, 32'(n_mul), 32'(exp_mul));
        check({tag, "_div_pulses"}, 32'(n_div), 32'(exp_div));
        check({tag, "_ready_edges"}, 32'(ready_k), 32'(exp_edges));
        check({tag, "_ready_pulses"}, 32'(n_ready), (exp_edges != 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        resetn          = 1'b0;
        sel             = 1'b0;
        drv_valid       = 1'b0;
        drv_flush       = 1'b0;
        drv_mul_ready   = 1'b0;
        drv_div_ready   = 1'b0;
        drv_f3          = 3'b000;
        drv_rs1         = '0;
        drv_rs2         = '0;
        drv_mul_product = '0;
        drv_div_result  = '0;

        #12;
        check("reset_result", if0.result, 32'h0);
        check("reset_ready", 32'(if0.ready), 32'h0);
        check("reset_mul_valid", 32'(if0.mul_valid), 32'h0);
        check("reset_div_valid", 32'(if0.div_valid), 32'h0);
        check("reset_factor1", if0.mul_factor1, 32'h0);
        check("reset_divisor", if0.div_divisor, 32'h0);
        check("reset_state", 32'(st0), 32'h0);
        check("reset_state_nc", 32'(st1), 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        // Multiplier path, result high word of the unsigned product
        run_op("mulhu", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, 1, 0, 4, 32'hFFFF_FFFE, 0);

        // Special divides complete without the divider
        run_op("div_by0",  F3_DIV,  32'd7, 32'd0, 32'hDEAD_BEEF, 2, 0, 0, 1, 32'hFFFF_FFFF, 0);
        run_op("remu_by0", F3_REMU, 32'd7, 32'd0, 32'hDEAD_BEEF, 2, 0, 0, 1, 32'd7, 0);
        run_op("div_ovf",  F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 2, 0, 0, 1, 32'h8000_0000, 0);
        run_op("rem_ovf",  F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 2, 0, 0, 1, 32'h0, 0);
        run_op("divu_max", F3_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 3, 0, 1, 5, 32'd1, 0);
        run_op("rem_neg",  F3_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1, 0, 1, 3, 32'hFFFF_FFFF, 0);

        // Cache: repeat hits, differing funct3 misses
        run_op("mul_first", F3_MUL,    32'd3, 32'hFFFF_FFFB, 32'hFFFF_FFF1, 1, 1, 0, 3, 32'hFFFF_FFF1, 0);
        run_op("mul_hit",   F3_MUL,    32'd3, 32'hFFFF_FFFB, 32'h0,         1, 0, 0, 1, 32'hFFFF_FFF1, 0);
        run_op("mulhsu",    F3_MULHSU, 32'd3, 32'hFFFF_FFFB, 32'd2,         2, 1, 0, 4, 32'd2, 0);
        run_op("mulh",      F3_MULH,   32'd3, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1, 1, 0, 3, 32'hFFFF_FFFF, 0);

        // Cache disabled: the repeat goes to the multiplier again
        sel = 1'b1;
        run_op("nc_mul1", F3_MUL, 32'd3, 32'hFFFF_FFFB, 32'hFFFF_FFF1, 1, 1, 0, 3, 32'hFFFF_FFF1, 0);
        run_op("nc_mul2", F3_MUL, 32'd3, 32'hFFFF_FFFB, 32'hFFFF_FFF1, 1, 1, 0, 3, 32'hFFFF_FFF1, 0);
        sel = 1'b0;

        // Flush in WAIT_DIV: no ready, completion drained, cache invalidated
        run_op("flush_wait",  F3_DIVU, 32'd100, 32'd7, 32'd14, 3, 0, 1, 0, 32'd0, 2);
        run_op("mulh_reissue", F3_MULH, 32'd3, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1, 1, 0, 3, 32'hFFFF_FFFF, 0);
        run_op("divu_after",  F3_DIVU, 32'd100, 32'd7, 32'd14, 3, 0, 1, 5, 32'd14, 0);
        run_op("divu_hit",    F3_DIVU, 32'd100, 32'd7, 32'd0,  3, 0, 0, 1, 32'd14, 0);

        // Flush in ISSUE_DIV: pulse still issued and drained; cache invalidated
        run_op("flush_issue", F3_DIV,  32'd100, 32'd7, 32'd14, 2, 0, 1, 0, 32'd0, 1);
        run_op("divu_miss",   F3_DIVU, 32'd100, 32'd7, 32'd14, 3, 0, 1, 5, 32'd14, 0);

        // Asynchronous reset while waiting on the multiplier
        @(negedge clk);
        drv_valid = 1'b1;
        drv_f3    = F3_MULHU;
        drv_rs1   = 32'hFFFF_FFFF;
        drv_rs2   = 32'd2;
        @(negedge clk);
        check("rst_issue_pulse", 32'(if0.mul_valid), 32'h1);
        @(negedge clk);
        check("rst_wait_factor1", if0.mul_factor1, 32'hFFFF_FFFF);
        #2;
        resetn = 1'b0;
        #1;
        check("rst_async_result", if0.result, 32'h0);
        check("rst_async_factor1", if0.mul_factor1, 32'h0);
        check("rst_async_factor2", if0.mul_factor2, 32'h0);
        check("rst_async_mul_op", 32'(if0.mul_op), 32'h0);
        check("rst_async_ready", 32'(if0.ready), 32'h0);
        check("rst_async_mul_valid", 32'(if0.mul_valid), 32'h0);
        check("rst_async_dividend", if0.div_dividend, 32'h0);
        @(negedge clk);
        drv_valid = 1'b0;
        resetn    = 1'b1;

        run_op("post_reset_mul", F3_MUL, 32'd6, 32'd7, 32'd42, 2, 1, 0, 4, 32'd42, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
